// File: rtl/sdram_burst_data_path_pkg.sv
// Shared SDRAM data-path definitions: FSM state encodings, legal burst/CAS
// settings and the beat-counter width helper.
package sdram_burst_data_path_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_BURST = 2'd1;
  localparam logic [1:0] ST_RD_WAIT  = 2'd2;
  localparam logic [1:0] ST_RD_BURST = 2'd3;

  localparam int CAS_LAT_MIN = 2;
  localparam int CAS_LAT_MAX = 3;

  function automatic bit burst_len_legal(input int burst_len);
    return (burst_len == 1) || (burst_len == 2) || (burst_len == 4) || (burst_len == 8);
  endfunction

  function automatic bit cas_lat_legal(input int cas_lat);
    return (cas_lat >= CAS_LAT_MIN) && (cas_lat <= CAS_LAT_MAX);
  endfunction

  // Must hold CAS_LAT+BURST_LEN, the final count of a read burst.
  function automatic int beat_cnt_w(input int cas_lat, input int burst_len);
    return $clog2(cas_lat + burst_len + 1);
  endfunction

endpackage

// File: rtl/sdram_dq_iobuf.sv
// DQ pad logic: registered write data and output enable driving the tristate
// bus, plus the read capture register with its valid flag.
module sdram_dq_iobuf #(
  parameter int DATA_W = 16
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              wr_load,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cap_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  logic              oe_q;
  logic [DATA_W-1:0] dq_out_q;

  // The enable follows the load strobe by one edge, so every loaded word is
  // driven for exactly one cycle; async reset releases the bus at once.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      oe_q     <= 1'b0;
      dq_out_q <= '0;
    end else begin
      oe_q <= wr_load;
      if (wr_load) dq_out_q <= wr_data;
    end
  end

  assign sdram_dq = oe_q ? dq_out_q : {DATA_W{1'bz}};

  // Captured data is held between bursts; only reset clears it.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= cap_en;
      if (cap_en) rd_data <= sdram_dq;
    end
  end

endmodule

// File: rtl/sdram_burst_data_path.sv
// SDRAM DQ burst data path: write/read burst sequencing above sdram_dq_iobuf.
// Optional per-byte write masks are enabled with SDRAM_DQM_MASK_EN.
module sdram_burst_data_path
  import sdram_burst_data_path_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int CAS_LAT   = 2
) (
  input  logic                clk_100m,
  input  logic                rst_n,
  input  logic                wr_start,
  input  logic                rd_start,
  input  logic [DATA_W-1:0]   sys_wr_data,
`ifdef SDRAM_DQM_MASK_EN
  input  logic [DATA_W/8-1:0] sys_wr_mask,
`endif
  output logic                sys_wr_req,
  output logic [DATA_W-1:0]   sys_rd_data,
  output logic                sys_rd_valid,
  output logic                busy,
  output logic                cmd_err,
  inout  wire  [DATA_W-1:0]   sdram_dq,
  output logic [DATA_W/8-1:0] sdram_dqm
);

  if (!burst_len_legal(BURST_LEN) || !cas_lat_legal(CAS_LAT) || (DATA_W % 8 != 0)) begin : g_param_check
    $error("sdram_burst_data_path: illegal DATA_W/BURST_LEN/CAS_LAT");
  end

  localparam int CNT_W = beat_cnt_w(CAS_LAT, BURST_LEN);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BL_C    = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CL_M1_C = CNT_W'(CAS_LAT - 1);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CAS_LAT + BURST_LEN);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_err_q;
  logic             idle;
  logic             cap_en;

  assign idle    = (state_q == ST_IDLE);
  assign busy    = !idle;
  assign cmd_err = cmd_err_q;

  // Count runs from 1 at the first busy cycle; write words are fetched while
  // count<BURST_LEN, read words are captured for counts CAS_LAT..CAS_LAT+BURST_LEN-1.
  assign sys_wr_req = rst_n & ((idle & wr_start) |
                               ((state_q == ST_WR_BURST) && (cnt_q < BL_C)));
  assign cap_en     = (state_q == ST_RD_BURST) && (cnt_q != LAST_C);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_start) begin
          state_d = ST_WR_BURST;
          cnt_d   = ONE_C;
        end else if (rd_start) begin
          state_d = ST_RD_WAIT;
          cnt_d   = ONE_C;
        end
      end
      ST_WR_BURST: begin
        if (cnt_q == BL_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == CL_M1_C) state_d = ST_RD_BURST;
      end
      ST_RD_BURST: begin
        if (cnt_q == LAST_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // In IDLE only a colliding read is rejected; when busy any start is.
      cmd_err_q <= idle ? (wr_start & rd_start) : (wr_start | rd_start);
    end
  end

  sdram_dq_iobuf #(
    .DATA_W(DATA_W)
  ) u_iobuf (
    .clk_100m(clk_100m),
    .rst_n   (rst_n),
    .wr_load (sys_wr_req),
    .wr_data (sys_wr_data),
    .cap_en  (cap_en),
    .rd_data (sys_rd_data),
    .rd_valid(sys_rd_valid),
    .sdram_dq(sdram_dq)
  );

`ifdef SDRAM_DQM_MASK_EN
  logic [DATA_W/8-1:0] dqm_q;

  // Loaded on the same edges as the DQ word and cleared otherwise, so the
  // mask is aligned with the driven data and zero during reads.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) dqm_q <= '0;
    else        dqm_q <= sys_wr_req ? sys_wr_mask : '0;
  end

  assign sdram_dqm = dqm_q;
`else
  assign sdram_dqm = '0;
`endif

endmodule

// File: tb/tb_sdram_burst_data_path.sv
// Directed bench for sdram_burst_data_path: cycle table for CAS 2 plus
// reset-abort, CAS 3 and (with SDRAM_DQM_MASK_EN) mask sequences.
module tb_sdram_burst_data_path;

  typedef struct packed {
    logic        wr_start;
    logic        rd_start;
    logic [15:0] wr_data;
    logic        dq_en;
    logic [15:0] dq_val;
    logic        exp_req;
    logic [15:0] exp_dq;
    logic        exp_busy;
    logic        exp_valid;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 26;

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  logic        rst_n;
  logic        wr_start, rd_start;
  logic [15:0] sys_wr_data;
  logic [1:0]  sys_wr_mask;
  logic        sys_wr_req, sys_rd_valid, busy, cmd_err;
  logic [15:0] sys_rd_data;
  logic [1:0]  sdram_dqm;
  logic        tb_dq_en;
  logic [15:0] tb_dq_val;
  wire  [15:0] dq_a;

  // Released bus floats to all ones, distinguishing high-Z from driven data.
  assign (weak0, weak1) dq_a = 16'hFFFF;
  assign dq_a = tb_dq_en ? tb_dq_val : 16'hzzzz;

  logic        rd_start_b;
  logic        sys_wr_req_b, sys_rd_valid_b, busy_b, cmd_err_b;
  logic [15:0] sys_rd_data_b;
  logic [1:0]  sdram_dqm_b;
  logic        tb_dq_en_b;
  logic [15:0] tb_dq_val_b;
  wire  [15:0] dq_b;

  assign (weak0, weak1) dq_b = 16'hFFFF;
  assign dq_b = tb_dq_en_b ? tb_dq_val_b : 16'hzzzz;

  sdram_burst_data_path #(.DATA_W(16), .BURST_LEN(4), .CAS_LAT(2)) u_dut (
    .clk_100m    (clk_100m),
    .rst_n       (rst_n),
    .wr_start    (wr_start),
    .rd_start    (rd_start),
    .sys_wr_data (sys_wr_data),
`ifdef SDRAM_DQM_MASK_EN
    .sys_wr_mask (sys_wr_mask),
`endif
    .sys_wr_req  (sys_wr_req),
    .sys_rd_data (sys_rd_data),
    .sys_rd_valid(sys_rd_valid),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .sdram_dq    (dq_a),
    .sdram_dqm   (sdram_dqm)
  );

  sdram_burst_data_path #(.DATA_W(16), .BURST_LEN(4), .CAS_LAT(3)) u_dut_cl3 (
    .clk_100m    (clk_100m),
    .rst_n       (rst_n),
    .wr_start    (1'b0),
    .rd_start    (rd_start_b),
    .sys_wr_data (16'h0000),
`ifdef SDRAM_DQM_MASK_EN
    .sys_wr_mask (2'b00),
`endif
    .sys_wr_req  (sys_wr_req_b),
    .sys_rd_data (sys_rd_data_b),
    .sys_rd_valid(sys_rd_valid_b),
    .busy        (busy_b),
    .cmd_err     (cmd_err_b),
    .sdram_dq    (dq_b),
    .sdram_dqm   (sdram_dqm_b)
  );

  int tests = 0;
  int fails = 0;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_100m);
    #1;
  endtask

  function automatic vec_t mk(input logic ws, input logic rs, input logic [15:0] wd,
                              input logic den, input logic [15:0] dval,
                              input logic req, input logic [15:0] dq, input logic bsy,
                              input logic vld, input logic [15:0] rd, input logic err);
    vec_t v;
    v = '{ws, rs, wd, den, dval, req, dq, bsy, vld, rd, err};
    return v;
  endfunction

  initial begin
    logic [15:0] exp_rd;

    // Write burst with a rejected read at T0+2, back-to-back read, colliding
    // starts, and a write start rejected during a read.
    vecs[0]  = mk(1, 0, 16'h1111, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h0000, 0);
    vecs[1]  = mk(0, 0, 16'h2222, 0, 16'h0000, 1, 16'h1111, 1, 0, 16'h0000, 0);
    vecs[2]  = mk(0, 1, 16'h3333, 0, 16'h0000, 1, 16'h2222, 1, 0, 16'h0000, 0);
    vecs[3]  = mk(0, 0, 16'h4444, 0, 16'h0000, 1, 16'h3333, 1, 0, 16'h0000, 1);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h4444, 1, 0, 16'h0000, 0);
    vecs[5]  = mk(0, 1, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 16'h0000, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 1, 0, 16'h0000, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 1, 16'hA0A0, 0, 16'hA0A0, 1, 0, 16'h0000, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 16'hA1A1, 0, 16'hA1A1, 1, 1, 16'hA0A0, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 1, 16'hA2A2, 0, 16'hA2A2, 1, 1, 16'hA1A1, 0);
    vecs[10] = mk(0, 0, 16'h0000, 1, 16'hA3A3, 0, 16'hA3A3, 1, 1, 16'hA2A2, 0);
    vecs[11] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 1, 1, 16'hA3A3, 0);
    vecs[12] = mk(1, 1, 16'h5555, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'hA3A3, 0);
    vecs[13] = mk(0, 0, 16'h6666, 0, 16'h0000, 1, 16'h5555, 1, 0, 16'hA3A3, 1);
    vecs[14] = mk(0, 0, 16'h7777, 0, 16'h0000, 1, 16'h6666, 1, 0, 16'hA3A3, 0);
    vecs[15] = mk(0, 0, 16'h8888, 0, 16'h0000, 1, 16'h7777, 1, 0, 16'hA3A3, 0);
    vecs[16] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h8888, 1, 0, 16'hA3A3, 0);
    vecs[17] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 16'hA3A3, 0);
    vecs[18] = mk(0, 1, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 16'hA3A3, 0);
    vecs[19] = mk(1, 0, 16'hDEAD, 0, 16'h0000, 0, 16'hFFFF, 1, 0, 16'hA3A3, 0);
    vecs[20] = mk(0, 0, 16'h0000, 1, 16'hB0B0, 0, 16'hB0B0, 1, 0, 16'hA3A3, 1);
    vecs[21] = mk(0, 0, 16'h0000, 1, 16'hB1B1, 0, 16'hB1B1, 1, 1, 16'hB0B0, 0);
    vecs[22] = mk(0, 0, 16'h0000, 1, 16'hB2B2, 0, 16'hB2B2, 1, 1, 16'hB1B1, 0);
    vecs[23] = mk(0, 0, 16'h0000, 1, 16'hB3B3, 0, 16'hB3B3, 1, 1, 16'hB2B2, 0);
    vecs[24] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 1, 1, 16'hB3B3, 0);
    vecs[25] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 16'hB3B3, 0);

    rst_n = 1'b0;
    wr_start = 1'b0; rd_start = 1'b0; sys_wr_data = '0; sys_wr_mask = '0;
    tb_dq_en = 1'b0; tb_dq_val = '0;
    rd_start_b = 1'b0; tb_dq_en_b = 1'b0; tb_dq_val_b = '0;
    repeat (2) @(posedge clk_100m);
    #1;

    // Reset state, with both starts asserted to confirm the request is gated.
    wr_start = 1'b1; rd_start = 1'b1; sys_wr_data = 16'h1111;
    @(negedge clk_100m);
    check("rst_req",   16'(sys_wr_req),   16'h0000);
    check("rst_dq",    dq_a,              16'hFFFF);
    check("rst_busy",  16'(busy),         16'h0000);
    check("rst_valid", 16'(sys_rd_valid), 16'h0000);
    check("rst_rd",    sys_rd_data,       16'h0000);
    check("rst_err",   16'(cmd_err),      16'h0000);
    check("rst_dqm",   16'(sdram_dqm),    16'h0000);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      wr_start    = vecs[i].wr_start;
      rd_start    = vecs[i].rd_start;
      sys_wr_data = vecs[i].wr_data;
      tb_dq_en    = vecs[i].dq_en;
      tb_dq_val   = vecs[i].dq_val;
      @(negedge clk_100m);
      check($sformatf("row%0d_req", i),   16'(sys_wr_req),   16'(vecs[i].exp_req));
      check($sformatf("row%0d_dq", i),    dq_a,              vecs[i].exp_dq);
      check($sformatf("row%0d_busy", i),  16'(busy),         16'(vecs[i].exp_busy));
      check($sformatf("row%0d_valid", i), 16'(sys_rd_valid), 16'(vecs[i].exp_valid));
      check($sformatf("row%0d_rd", i),    sys_rd_data,       vecs[i].exp_rd);
      check($sformatf("row%0d_err", i),   16'(cmd_err),      16'(vecs[i].exp_err));
`ifndef SDRAM_DQM_MASK_EN
      check($sformatf("row%0d_dqm", i),   16'(sdram_dqm),    16'h0000);
`endif
      next_cycle();
    end
    wr_start = 1'b0; rd_start = 1'b0; tb_dq_en = 1'b0;

    // Reset asserted during the second driven beat of a write.
    wr_start = 1'b1; sys_wr_data = 16'h1234;
    next_cycle();
    wr_start = 1'b0; sys_wr_data = 16'h5678;
    @(negedge clk_100m);
    check("abort_beat1_dq", dq_a, 16'h1234);
    next_cycle();
    @(negedge clk_100m);
    check("abort_beat2_dq", dq_a, 16'h5678);
    #1;
    rst_n = 1'b0; wr_start = 1'b1;
    #1;
    check("abort_dq",    dq_a,              16'hFFFF);
    check("abort_req",   16'(sys_wr_req),   16'h0000);
    check("abort_busy",  16'(busy),         16'h0000);
    check("abort_valid", 16'(sys_rd_valid), 16'h0000);
    check("abort_rd",    sys_rd_data,       16'h0000);
    check("abort_err",   16'(cmd_err),      16'h0000);
    next_cycle();
    rst_n = 1'b1; wr_start = 1'b0;

    // Read started in the first cycle after release.
    for (int k = 0; k < 8; k++) begin
      rd_start  = (k == 0);
      tb_dq_en  = (k >= 2) && (k <= 5);
      tb_dq_val = 16'hC0C0 + 16'h0101 * 16'(k - 2);
      @(negedge clk_100m);
      exp_rd = (k < 3) ? 16'h0000 : 16'hC0C0 + 16'h0101 * 16'((k > 6) ? 3 : k - 3);
      check($sformatf("post_rst%0d_busy", k),  16'(busy),         16'((k >= 1) && (k <= 6)));
      check($sformatf("post_rst%0d_valid", k), 16'(sys_rd_valid), 16'((k >= 3) && (k <= 6)));
      check($sformatf("post_rst%0d_rd", k),    sys_rd_data,       exp_rd);
      next_cycle();
    end
    rd_start = 1'b0; tb_dq_en = 1'b0;

    // CAS latency 3: every read event shifts by one cycle.
    for (int k = 0; k < 9; k++) begin
      rd_start_b  = (k == 0);
      tb_dq_en_b  = (k >= 3) && (k <= 6);
      tb_dq_val_b = 16'hD0D0 + 16'h0101 * 16'(k - 3);
      @(negedge clk_100m);
      exp_rd = (k < 4) ? 16'h0000 : 16'hD0D0 + 16'h0101 * 16'((k > 7) ? 3 : k - 4);
      check($sformatf("cl3_%0d_busy", k),  16'(busy_b),         16'((k >= 1) && (k <= 7)));
      check($sformatf("cl3_%0d_valid", k), 16'(sys_rd_valid_b), 16'((k >= 4) && (k <= 7)));
      check($sformatf("cl3_%0d_rd", k),    sys_rd_data_b,       exp_rd);
      check($sformatf("cl3_%0d_err", k),   16'(cmd_err_b),      16'h0000);
      next_cycle();
    end
    rd_start_b = 1'b0; tb_dq_en_b = 1'b0;

`ifdef SDRAM_DQM_MASK_EN
    // Mask pattern 00,01,10,11 must appear on DQM alongside words 0..3.
    for (int k = 0; k < 6; k++) begin
      wr_start    = (k == 0);
      sys_wr_data = 16'hE000 + 16'(k);
      sys_wr_mask = 2'(k);
      @(negedge clk_100m);
      check($sformatf("mask%0d_dqm", k), 16'(sdram_dqm),
            ((k >= 1) && (k <= 4)) ? 16'(k - 1) : 16'h0000);
      next_cycle();
    end
    wr_start = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
